// File: rtl/register_file_2r1w_if.sv
// Bus bundle for the 2-read / 1-write register file: one write port and two
// independent read ports (A and B), each read port returning data plus a
// one-cycle valid flag.
interface register_file_2r1w_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [WIDTH-1:0]  rd_data_a;
    logic              rd_valid_a;

    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_b;
    logic              rd_valid_b;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
    );
endinterface

// File: rtl/register_file_2r1w.sv
// Parametrised register file: NUM_REGS words of WIDTH bits, one synchronous
// write port, two registered read ports with valid flags and optional
// write-to-read bypass. Entry 0 can be hardwired to zero (R0 convention).
// Out-of-range addresses read as zero, are never written, and never index
// the storage array directly (all lookups are compare-and-select).
module register_file_2r1w #(
    parameter int WIDTH     = 32,
    parameter int NUM_REGS  = 16,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 1
) (
    input  logic                clk,
    input  logic                clr,
    register_file_2r1w_if.slave bus
);

    // One extra bit so NUM_REGS itself is representable (e.g. 256 with 8-bit addresses).
    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);
    localparam bit              ZERO_EN    = (ZERO_REG0 != 32'sd0);
    localparam bit              BYPASS_EN  = (BYPASS != 32'sd0);

    logic [WIDTH-1:0]  mem_r [NUM_REGS];
    logic              wr_ok_s;
    logic [1:0]        rd_en_s;
    logic [ADDR_W-1:0] rd_addr_s [2];
    logic [WIDTH-1:0]  sel_s [2];
    logic [WIDTH-1:0]  data_r [2];
    logic [1:0]        valid_r;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < NUM_REGS_L);
    endfunction

    // Stored word at addr, built as an OR of per-entry matches (zero when no entry matches).
    function automatic logic [WIDTH-1:0] stored_word(input logic [ADDR_W-1:0] addr,
                                                     input logic [WIDTH-1:0] mem [NUM_REGS]);
        logic [WIDTH-1:0] v;
        v = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            v = v | ((addr == ADDR_W'(i)) ? mem[i] : {WIDTH{1'b0}});
        end
        return v;
    endfunction

    assign rd_en_s      = {bus.rd_en_b, bus.rd_en_a};
    assign rd_addr_s[0] = bus.rd_addr_a;
    assign rd_addr_s[1] = bus.rd_addr_b;

    // Decide whether this cycle's write lands in storage (in range, not the zero register).
    always_comb begin
        wr_ok_s = 1'b0;
        if (bus.wr_en && in_range(bus.wr_addr)) begin
            if (ZERO_EN && (bus.wr_addr == {ADDR_W{1'b0}})) begin
                wr_ok_s = 1'b0;
            end else begin
                wr_ok_s = 1'b1;
            end
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Storage array: cleared asynchronously, written one entry per cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok_s && (bus.wr_addr == ADDR_W'(i))) begin
                    mem_r[i] <= bus.wr_data;
                end
            end
        end
    end

    // Read value per port: out-of-range beats hardwired zero beats bypass beats storage.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            sel_s[p] = {WIDTH{1'b0}};
            if (!in_range(rd_addr_s[p])) begin
                sel_s[p] = {WIDTH{1'b0}};
            end else if (ZERO_EN && (rd_addr_s[p] == {ADDR_W{1'b0}})) begin
                sel_s[p] = {WIDTH{1'b0}};
            end else if (BYPASS_EN && bus.wr_en && (bus.wr_addr == rd_addr_s[p])) begin
                sel_s[p] = bus.wr_data;
            end else begin
                sel_s[p] = stored_word(rd_addr_s[p], mem_r);
            end
        end
    end

    // Registered read ports: data captured on enable and held otherwise; valid is per-cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            data_r[0] <= {WIDTH{1'b0}};
            data_r[1] <= {WIDTH{1'b0}};
            valid_r   <= 2'b00;
        end else begin
            valid_r <= rd_en_s;
            for (int p = 0; p < 2; p++) begin
                if (rd_en_s[p]) begin
                    data_r[p] <= sel_s[p];
                end
            end
        end
    end

    assign bus.rd_data_a  = data_r[0];
    assign bus.rd_valid_a = valid_r[0];
    assign bus.rd_data_b  = data_r[1];
    assign bus.rd_valid_b = valid_r[1];

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w. Two instances share identical stimulus:
// dut0 = 16 regs, zero R0, bypass; dut1 = 12 regs, no zero R0, no bypass.
// A directed table, a reset sequence and a random run against an array model.
module tb_register_file_2r1w;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    register_file_2r1w_if #(.WIDTH(32), .ADDR_W(4)) bus0 ();
    register_file_2r1w_if #(.WIDTH(32), .ADDR_W(4)) bus1 ();

    register_file_2r1w #(.WIDTH(32), .NUM_REGS(16), .ZERO_REG0(1), .BYPASS(1))
        dut0 (.clk(clk), .clr(clr), .bus(bus0));
    register_file_2r1w #(.WIDTH(32), .NUM_REGS(12), .ZERO_REG0(0), .BYPASS(0))
        dut1 (.clk(clk), .clr(clr), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain array per instance plus expected port outputs.
    logic [31:0] ref_mem   [2][16];
    logic [31:0] exp_data  [2][2];
    logic        exp_valid [2][2];

    typedef struct {
        logic        we;  logic [3:0] wa; logic [31:0] wd;
        logic        rea; logic [3:0] ra;
        logic        reb; logic [3:0] rb;
        logic [31:0] d0a; logic [31:0] d0b; logic [31:0] d1a; logic [31:0] d1b;
        logic        va;  logic        vb;
    } vec_t;
    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    function automatic int regs_of(input int d);
        return (d == 0) ? 16 : 12;
    endfunction

    function automatic logic [31:0] model_sel(input int d, input int addr, input logic we,
                                              input int wa, input logic [31:0] wd);
        if (addr >= regs_of(d)) return 32'h0;
        if (d == 0 && addr == 0) return 32'h0;
        if (d == 0 && we && wa == addr) return wd;
        return ref_mem[d][addr];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) ref_mem[d][i] = 32'h0;
            for (int p = 0; p < 2; p++) begin
                exp_data[d][p]  = 32'h0;
                exp_valid[d][p] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic rea, input logic [3:0] ra,
                        input logic reb, input logic [3:0] rb);
        bus0.wr_en = we;  bus0.wr_addr = wa; bus0.wr_data = wd;
        bus0.rd_en_a = rea; bus0.rd_addr_a = ra; bus0.rd_en_b = reb; bus0.rd_addr_b = rb;
        bus1.wr_en = we;  bus1.wr_addr = wa; bus1.wr_data = wd;
        bus1.rd_en_a = rea; bus1.rd_addr_a = ra; bus1.rd_en_b = reb; bus1.rd_addr_b = rb;
        for (int d = 0; d < 2; d++) begin
            exp_valid[d][0] = rea;
            exp_valid[d][1] = reb;
            if (rea) exp_data[d][0] = model_sel(d, int'(ra), we, int'(wa), wd);
            if (reb) exp_data[d][1] = model_sel(d, int'(rb), we, int'(wa), wd);
            if (we && int'(wa) < regs_of(d) && !(d == 0 && wa == 4'd0))
                ref_mem[d][wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " d0 data_a"},  bus0.rd_data_a,          exp_data[0][0]);
        check({tag, " d0 data_b"},  bus0.rd_data_b,          exp_data[0][1]);
        check({tag, " d0 valid_a"}, {31'h0, bus0.rd_valid_a}, {31'h0, exp_valid[0][0]});
        check({tag, " d0 valid_b"}, {31'h0, bus0.rd_valid_b}, {31'h0, exp_valid[0][1]});
        check({tag, " d1 data_a"},  bus1.rd_data_a,          exp_data[1][0]);
        check({tag, " d1 data_b"},  bus1.rd_data_b,          exp_data[1][1]);
        check({tag, " d1 valid_a"}, {31'h0, bus1.rd_valid_a}, {31'h0, exp_valid[1][0]});
        check({tag, " d1 valid_b"}, {31'h0, bus1.rd_valid_b}, {31'h0, exp_valid[1][1]});
    endtask

    task automatic check_const(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                               input logic v);
        check({tag, " d0 data_a"},  bus0.rd_data_a,           d0);
        check({tag, " d0 data_b"},  bus0.rd_data_b,           d0);
        check({tag, " d1 data_a"},  bus1.rd_data_a,           d1);
        check({tag, " d1 data_b"},  bus1.rd_data_b,           d1);
        check({tag, " d0 valid_a"}, {31'h0, bus0.rd_valid_a}, {31'h0, v});
        check({tag, " d0 valid_b"}, {31'h0, bus0.rd_valid_b}, {31'h0, v});
        check({tag, " d1 valid_a"}, {31'h0, bus1.rd_valid_a}, {31'h0, v});
        check({tag, " d1 valid_b"}, {31'h0, bus1.rd_valid_b}, {31'h0, v});
    endtask

    initial begin
        //          we    wa     wd            rea   ra     reb   rb     d0a           d0b           d1a           d1b           va    vb
        vecs[0]  = '{1'b1, 4'd3,  32'h12345678, 1'b0, 4'd0,  1'b0, 4'd0,  32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd3,  1'b0, 4'd0,  32'h12345678, 32'h0,        32'h12345678, 32'h0,        1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd3,  1'b0, 4'd0,  32'h12345678, 32'h0,        32'h12345678, 32'h0,        1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'd7,  32'h1,        1'b0, 4'd0,  1'b0, 4'd0,  32'h12345678, 32'h0,        32'h12345678, 32'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'd7,  32'hA5A5A5A5, 1'b0, 4'd0,  1'b1, 4'd7,  32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'h1,        1'b0, 1'b1};
        vecs[5]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  1'b1, 4'd7,  32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 4'd0,  32'hFFFFFFFF, 1'b0, 4'd0,  1'b0, 4'd0,  32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd0,  1'b1, 4'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 4'd0,  32'h11223344, 1'b1, 4'd0,  1'b1, 4'd3,  32'h0,        32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 4'd13, 32'h55,       1'b0, 4'd0,  1'b0, 4'd0,  32'h0,        32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd13, 1'b1, 4'd11, 32'h55,       32'h0,        32'h0,        32'h0,        1'b1, 1'b1};
        vecs[11] = '{1'b1, 4'd11, 32'hCAFEF00D, 1'b1, 4'd11, 1'b1, 4'd11, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h0,        1'b1, 1'b1};
        vecs[12] = '{1'b1, 4'd12, 32'h77,       1'b1, 4'd15, 1'b1, 4'd12, 32'h0,        32'h77,       32'h0,        32'h0,        1'b1, 1'b1};
        vecs[13] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd12, 1'b1, 4'd11, 32'h77,       32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd0,  1'b0, 4'd0,  32'h0,        32'hCAFEF00D, 32'h11223344, 32'hCAFEF00D, 1'b1, 1'b0};

        model_reset();
        bus0.wr_en = 1'b0; bus0.wr_addr = 4'd0; bus0.wr_data = 32'h0;
        bus0.rd_en_a = 1'b0; bus0.rd_addr_a = 4'd0; bus0.rd_en_b = 1'b0; bus0.rd_addr_b = 4'd0;
        bus1.wr_en = 1'b0; bus1.wr_addr = 4'd0; bus1.wr_data = 32'h0;
        bus1.rd_en_a = 1'b0; bus1.rd_addr_a = 4'd0; bus1.rd_en_b = 1'b0; bus1.rd_addr_b = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_const("reset", 32'h0, 32'h0, 1'b0);
        clr = 1'b1;

        // Directed table.
        for (int k = 0; k < 15; k++) begin
            step(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].rea, vecs[k].ra, vecs[k].reb, vecs[k].rb);
            check($sformatf("vec%0d d0 data_a", k), bus0.rd_data_a, vecs[k].d0a);
            check($sformatf("vec%0d d0 data_b", k), bus0.rd_data_b, vecs[k].d0b);
            check($sformatf("vec%0d d1 data_a", k), bus1.rd_data_a, vecs[k].d1a);
            check($sformatf("vec%0d d1 data_b", k), bus1.rd_data_b, vecs[k].d1b);
            check($sformatf("vec%0d valid_a", k), {31'h0, bus0.rd_valid_a & bus1.rd_valid_a}, {31'h0, vecs[k].va});
            check($sformatf("vec%0d valid_b", k), {31'h0, bus0.rd_valid_b & bus1.rd_valid_b}, {31'h0, vecs[k].vb});
            check($sformatf("vec%0d valid_any", k), {31'h0, bus0.rd_valid_a | bus1.rd_valid_a | bus0.rd_valid_b | bus1.rd_valid_b},
                  {31'h0, vecs[k].va | vecs[k].vb});
        end

        // Mid-run reset: in-flight data and valid vanish at once, storage clears.
        step(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 4'd0);
        step(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b1, 4'd5);
        check_const("pre-reset read5", 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        bus0.rd_en_a = 1'b1; bus1.rd_en_a = 1'b1;
        clr = 1'b0;
        model_reset();
        #2;
        check_const("async clr", 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_const("clr held", 32'h0, 32'h0, 1'b0);
        clr = 1'b1;
        step(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b1, 4'd5);
        check_const("post-reset read5", 32'h0, 32'h0, 1'b1);

        // Random dual-port traffic against the model.
        for (int c = 0; c < 200; c++) begin
            logic        we, rea, reb;
            logic [3:0]  wa, ra, rb;
            logic [31:0] wd;
            we  = ($urandom_range(0, 2) != 0);
            wa  = 4'($urandom_range(0, 15));
            wd  = $urandom;
            rea = ($urandom_range(0, 3) != 0);
            reb = ($urandom_range(0, 3) != 0);
            ra  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            rb  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            step(we, wa, wd, rea, ra, reb, rb);
            check_model($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
